config_shifter: RTL and testbench

Byte-to-serial bridge between the command decoder and the logic block's configuration scan chain. It accepts one configuration byte per valid/ready handshake and shifts it LSB-first into the chain through SHIFT_HEAD with SHIFT_ENABLE pulses. At the same time it captures the bits leaving the chain on SHIFT_TAIL into a readback byte, which it presents through a second valid/ready handshake for return to the UART transmitter.

---
 rtl/config_shifter.sv | 86 ++++++++
 tb/tb_config_shifter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/config_shifter.sv
// Byte-to-serial bridge for the logic block configuration scan chain.
// Ports: SCLK/RESET; IN_VALID/IN_READY/IN_DATA byte in; OUT_VALID/
// OUT_READY/OUT_DATA readback out; SHIFT_HEAD/SHIFT_TAIL/SHIFT_ENABLE
// to the chain; BUSY high while shifting or holding a readback byte.
module config_shifter #(
  parameter int DIV = 1
) (
  input  logic       SCLK,
  input  logic       RESET,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic [7:0] IN_DATA,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic [7:0] OUT_DATA,
  output logic       SHIFT_HEAD,
  input  logic       SHIFT_TAIL,
  output logic       SHIFT_ENABLE,
  output logic       BUSY
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t         state;
  logic [7:0]     sreg;
  logic [2:0]     bit_cnt;
  logic [DW-1:0]  div_cnt;
  logic           tick;

  // One chain strobe at the end of each DIV-cycle bit window.
  assign tick = (state == SHIFT) && (div_cnt == DLAST);

  always_ff @(posedge SCLK) begin
    if (RESET) begin
      state   <= IDLE;
      sreg    <= 8'h00;
      bit_cnt <= 3'd0;
      div_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (IN_VALID) begin
            sreg    <= IN_DATA;
            bit_cnt <= 3'd0;
            div_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            // Tail bit is the pre-shift value the chain presents now.
            sreg    <= {SHIFT_TAIL, sreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            div_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state <= DONE;
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        DONE: begin
          if (OUT_READY) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign IN_READY     = (state == IDLE);
  assign BUSY         = (state != IDLE);
  assign OUT_VALID    = (state == DONE);
  assign OUT_DATA     = (state == DONE) ? sreg : 8'h00;
  assign SHIFT_HEAD   = (state == SHIFT) & sreg[0];
  assign SHIFT_ENABLE = tick;

endmodule

// File: tb/tb_config_shifter.sv
// Directed bench for config_shifter with DIV=1 and DIV=4 instances,
// each attached to an 8-bit scan chain model.
module tb_config_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       ordy;

  logic       iv1, ir1, ov1, hd1, tl1, en1, bz1;
  logic [7:0] od1;
  logic       iv4, ir4, ov4, hd4, tl4, en4, bz4;
  logic [7:0] od4;

  logic [7:0] chain1, chain4, ldv;
  logic       ld1, ld4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  config_shifter #(.DIV(1)) u1 (
    .SCLK(clk), .RESET(rst), .IN_VALID(iv1), .IN_READY(ir1),
    .IN_DATA(din), .OUT_VALID(ov1), .OUT_READY(ordy), .OUT_DATA(od1),
    .SHIFT_HEAD(hd1), .SHIFT_TAIL(tl1), .SHIFT_ENABLE(en1), .BUSY(bz1)
  );

  config_shifter #(.DIV(4)) u4 (
    .SCLK(clk), .RESET(rst), .IN_VALID(iv4), .IN_READY(ir4),
    .IN_DATA(din), .OUT_VALID(ov4), .OUT_READY(ordy), .OUT_DATA(od4),
    .SHIFT_HEAD(hd4), .SHIFT_TAIL(tl4), .SHIFT_ENABLE(en4), .BUSY(bz4)
  );

  // Chain models: head enters at bit 7, tail leaves from bit 0.
  assign tl1 = chain1[0];
  assign tl4 = chain4[0];

  always @(posedge clk) begin
    if (ld1) chain1 <= ldv;
    else if (en1) chain1 <= {hd1, chain1[7:1]};
    if (ld4) chain4 <= ldv;
    else if (en4) chain4 <= {hd4, chain4[7:1]};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load1(input logic [7:0] v);
    ldv = v; ld1 = 1'b1; step(); ld1 = 1'b0;
  endtask

  task automatic load4(input logic [7:0] v);
    ldv = v; ld4 = 1'b1; step(); ld4 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    total++; if (ir1 !== 1'b1) begin bad++; $display("FAIL rst_in_ready got %b want 1", ir1); end
    total++; if (en1 !== 1'b0) begin bad++; $display("FAIL rst_enable got %b want 0", en1); end
    total++; if (hd1 !== 1'b0) begin bad++; $display("FAIL rst_head got %b want 0", hd1); end
    total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %b want 0", ov1); end
    total++; if (od1 !== 8'h00) begin bad++; $display("FAIL rst_out_data got %h want 00", od1); end
    total++; if (bz1 !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", bz1); end
    total++; if ({ir4, en4, ov4, bz4} !== 4'b1000) begin bad++; $display("FAIL rst_div4 got %b want 1000", {ir4, en4, ov4, bz4}); end
  endtask

  task automatic test_basic();
    int n;
    load1(8'h3C);
    ordy = 1'b1; din = 8'hA5; iv1 = 1'b1;
    step(); iv1 = 1'b0;
    n = 0;
    for (int k = 1; k <= 8; k++) begin
      total++; if (en1 !== 1'b1) begin bad++; $display("FAIL basic_enable c%0d got %b want 1", k, en1); end
      total++; if (hd1 !== din[k-1]) begin bad++; $display("FAIL basic_head c%0d got %b want %b", k, hd1, din[k-1]); end
      step();
    end
    total++; if (en1 !== 1'b0) begin bad++; $display("FAIL basic_enable_end got %b want 0", en1); end
    total++; if (ov1 !== 1'b1) begin bad++; $display("FAIL basic_out_valid got %b want 1", ov1); end
    total++; if (od1 !== 8'h3C) begin bad++; $display("FAIL basic_out_data got %h want 3c", od1); end
    step();
    total++; if (ir1 !== 1'b1) begin bad++; $display("FAIL basic_in_ready got %b want 1", ir1); end
    total++; if (chain1 !== 8'hA5) begin bad++; $display("FAIL basic_chain got %h want a5", chain1); end
    ordy = 1'b0;
  endtask

  task automatic test_divided();
    logic h;
    h = 1'b0;
    load4(8'h96);
    ordy = 1'b0; din = 8'h81; iv4 = 1'b1;
    step(); iv4 = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      total++; if (en4 !== (k % 4 == 0)) begin bad++; $display("FAIL div_enable c%0d got %b", k, en4); end
      if (k % 4 == 1) h = hd4;
      total++; if (hd4 !== h || hd4 !== din[(k-1)/4]) begin bad++; $display("FAIL div_head c%0d got %b want %b", k, hd4, din[(k-1)/4]); end
      total++; if (ov4 !== 1'b0) begin bad++; $display("FAIL div_early_valid c%0d got %b want 0", k, ov4); end
      step();
    end
    total++; if (ov4 !== 1'b1) begin bad++; $display("FAIL div_out_valid got %b want 1", ov4); end
    total++; if (od4 !== 8'h96) begin bad++; $display("FAIL div_out_data got %h want 96", od4); end
    total++; if (chain4 !== 8'h81) begin bad++; $display("FAIL div_chain got %h want 81", chain4); end
    ordy = 1'b1; step(); ordy = 1'b0;
    total++; if (ir4 !== 1'b1) begin bad++; $display("FAIL div_in_ready got %b want 1", ir4); end
  endtask

  task automatic test_backpressure();
    load1(8'h12);
    ordy = 1'b0; din = 8'h33; iv1 = 1'b1;
    step(); iv1 = 1'b0;
    for (int k = 0; k < 8; k++) step();
    din = 8'h55; iv1 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      total++; if ({ov1, ir1, en1} !== 3'b100) begin bad++; $display("FAIL bp_ctrl c%0d got %b want 100", k, {ov1, ir1, en1}); end
      total++; if (od1 !== 8'h12) begin bad++; $display("FAIL bp_data c%0d got %h want 12", k, od1); end
      step();
    end
    ordy = 1'b1; step(); ordy = 1'b0;
    total++; if ({ir1, ov1} !== 2'b10) begin bad++; $display("FAIL bp_release got %b want 10", {ir1, ov1}); end
    step(); iv1 = 1'b0;
    total++; if ({bz1, en1} !== 2'b11) begin bad++; $display("FAIL bp_accept got %b want 11", {bz1, en1}); end
    for (int k = 0; k < 8; k++) step();
    total++; if (od1 !== 8'h33) begin bad++; $display("FAIL bp_readback got %h want 33", od1); end
    ordy = 1'b1; step(); ordy = 1'b0;
    total++; if (chain1 !== 8'h55) begin bad++; $display("FAIL bp_chain got %h want 55", chain1); end
  endtask

  task automatic test_reset_mid();
    int n;
    din = 8'hFF; iv1 = 1'b1;
    step(); iv1 = 1'b0;
    step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    total++; if ({en1, ov1, bz1, ir1} !== 4'b0001) begin bad++; $display("FAIL midrst_ctrl got %b want 0001", {en1, ov1, bz1, ir1}); end
    total++; if (chain1 !== 8'hEA) begin bad++; $display("FAIL midrst_chain got %h want ea", chain1); end
    iv1 = 1'b1;
    step(); iv1 = 1'b0;
    n = 0;
    for (int k = 0; k < 9; k++) begin
      if (en1 === 1'b1) n++;
      if (k < 8) step();
    end
    total++; if (n !== 8) begin bad++; $display("FAIL midrst_pulses got %0d want 8", n); end
    total++; if (od1 !== 8'hEA) begin bad++; $display("FAIL midrst_readback got %h want ea", od1); end
    ordy = 1'b1; step(); ordy = 1'b0;
    total++; if (chain1 !== 8'hFF) begin bad++; $display("FAIL midrst_chain_end got %h want ff", chain1); end
  endtask

  task automatic test_back_to_back();
    load1(8'h00);
    ordy = 1'b1; din = 8'h01; iv1 = 1'b1;
    step();
    din = 8'h80;
    for (int k = 0; k < 8; k++) step();
    total++; if ({ov1, od1} !== {1'b1, 8'h00}) begin bad++; $display("FAIL b2b_first got %b/%h want 1/00", ov1, od1); end
    step();
    total++; if (ir1 !== 1'b1) begin bad++; $display("FAIL b2b_ready got %b want 1", ir1); end
    step(); iv1 = 1'b0;
    for (int k = 0; k < 8; k++) step();
    total++; if ({ov1, od1} !== {1'b1, 8'h01}) begin bad++; $display("FAIL b2b_second got %b/%h want 1/01", ov1, od1); end
    step(); ordy = 1'b0;
    total++; if (chain1 !== 8'h80) begin bad++; $display("FAIL b2b_chain got %h want 80", chain1); end
  endtask

  initial begin
    rst = 1'b1; din = 8'h00; ordy = 1'b0;
    iv1 = 1'b0; iv4 = 1'b0; ld1 = 1'b0; ld4 = 1'b0; ldv = 8'h00;
    test_reset();
    test_basic();
    test_divided();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
